nrisc_trace_buffer: RTL and testbench
=====================================

Name: nrisc_trace_buffer

Overview:
Downstream observation stage for the nRISC core. Each clock it samples the core's architectural outputs: PC, ALU result, memory read/write values and the nine control signals. Samples are stamped with a cycle count and pushed into an on-chip FIFO, which a bench or debug host drains through a valid/ready port. The block also raises a halt request once a programmed number of cycles has been captured, replacing ad-hoc stop counters in simulation.

Parameters:
DEPTH, 32, FIFO entries; power of two, minimum 4.
STAMP_W, 16, width of the cycle stamp counter.
STOP_COUNT, 30, captured-cycle count that raises halt_req; 0 disables halt.

Ports:
clock  in  1  single system clock; all state updates on its rising edge.
reset  in  1  asynchronous, active-low reset.
arm  in  1  one-cycle pulse; IDLE→ARMED.
clear  in  1  synchronous flush of FIFO, counters, flags and state to IDLE; has priority over all other inputs except reset.
core_valid  in  1  core is out of reset and executing; qualifies sampling.
pc_in  in  8  core PC.
alu_result  in  8  ALU output.
mem_rdata  in  8  data-memory read value.
mem_wdata  in  8  data-memory write value.
ctrl_in  in  10  {alu_op[1:0], reg_dst, mem_to_reg, jump, branch, mem_read, mem_write, alu_src, reg_write}.
rd_ready  in  1  consumer accepts the head entry.
rd_valid  out  1  FIFO not empty.
rd_data  out  58  head entry {stamp[15:0], ctrl[9:0], pc[7:0], alu[7:0], rdata[7:0], wdata[7:0]}; MSB first.
level  out  6  current occupancy, 0..DEPTH.
overflow  out  1  sticky: a sample was dropped because the FIFO was full.
halt_req  out  1  sticky: captured count reached STOP_COUNT.
busy  out  1  high in ARMED or CAPTURE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, FIFO pointers=0, level=0, stamp=0, captured=0, rd_valid=0, rd_data=0, overflow=0, halt_req=0, busy=0.
- States:
  - IDLE: arm→ARMED.
  - ARMED: first cycle with core_valid=1 →CAPTURE; that cycle's sample is pushed with stamp=0.
  - CAPTURE: every cycle with core_valid=1 pushes one sample and increments stamp. A core_valid=0 cycle pushes nothing, but stamp still increments, so gaps are visible in the trace.
  - CAPTURE→DONE on the edge where captured becomes STOP_COUNT; halt_req sets on the same edge.
  - DONE: no pushes; draining continues. Only clear returns the block to IDLE; arm is ignored in DONE.
- Push latency: inputs sampled at edge N appear in the FIFO after edge N. If the FIFO was empty, rd_valid=1 after edge N (1-cycle latency).
- Pop: rd_valid&rd_ready at an edge removes the head. rd_data is combinational from the head entry and is held stable while rd_valid=1 and rd_ready=0.
- Simultaneous push and pop:
  - Not full: level unchanged.
  - Full: the pop frees a slot and the push is accepted; overflow is not set.
- Full with push and no pop: the sample is dropped and overflow sets. captured and stamp still increment.
- Empty with rd_ready=1: no effect.
- Pointers wrap modulo DEPTH. Stamp wraps modulo 2^STAMP_W without flagging. captured saturates at STOP_COUNT.
- STOP_COUNT=0: halt_req never asserts; CAPTURE persists until clear.
- clear while a transfer is in flight: the pop is discarded and the FIFO is empty next cycle. arm in the same cycle as clear is ignored.
- Reset mid-CAPTURE: everything returns to reset values immediately; FIFO contents are discarded (treated as invalid).

Test Plan:
1. Reset, arm, core_valid=1 from cycle 3, pc_in incrementing 0x00..; rd_ready=0 -> level rises 1 per cycle; head rd_data stamp=0, pc=0x00; no overflow before level=32.
2. Continue test 1 with STOP_COUNT=30 -> halt_req=1 on the edge of the 30th capture; state DONE; level=30; further core_valid ignored; draining 30 entries yields stamps 0..29 in order, then rd_valid=0.
3. DEPTH=4, STOP_COUNT=0, rd_ready=0, 6 samples -> level=4, overflow=1 after the 5th sample, FIFO holds stamps 0..3. Then rd_ready=1 together with a push at full -> level stays 4, overflow unchanged.
4. core_valid toggled 1,0,1,1 in CAPTURE -> entries stamped 0,2,3; no entry for stamp 1.
5. rd_ready held 0 with rd_valid=1 for 5 cycles while pushes continue -> rd_data constant (head stamp 0). rd_ready pulse -> next head stamp 1.
6. reset=0 asserted asynchronously mid-CAPTURE with level=7 -> all outputs return to reset values before the next clock edge. clear mid-drain -> level=0, rd_valid=0, state IDLE next cycle.

Source files
------------

// File: rtl/nrisc_trace_buffer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module     : nrisc_trace_buffer
// Description: Captures per-cycle nRISC architectural outputs with a cycle
//              stamp into a FIFO drained over valid/ready; raises halt_req
//              after a programmed number of captured cycles.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
module nrisc_trace_buffer #(
    parameter int DEPTH      = 32,
    parameter int STAMP_W    = 16,
    parameter int STOP_COUNT = 30
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 clear,
    input  logic                 core_valid,
    input  logic [7:0]           pc_in,
    input  logic [7:0]           alu_result,
    input  logic [7:0]           mem_rdata,
    input  logic [7:0]           mem_wdata,
    input  logic [9:0]           ctrl_in,
    input  logic                 rd_ready,
    output logic                 rd_valid,
    output logic [STAMP_W+41:0]  rd_data,
    output logic [5:0]           level,
    output logic                 overflow,
    output logic                 halt_req,
    output logic                 busy
);

    localparam int c_addr_w  = $clog2(DEPTH);
    localparam int c_cnt_w   = c_addr_w + 1;
    localparam int c_cap_w   = $clog2(STOP_COUNT + 2);
    localparam int c_entry_w = STAMP_W + 42;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t               r_state;
    logic [STAMP_W-1:0]   r_stamp;
    logic [c_cap_w-1:0]   r_captured;
    logic [c_addr_w-1:0]  r_wptr;
    logic [c_addr_w-1:0]  r_rptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_overflow;
    logic                 r_halt;
    logic [c_entry_w-1:0] r_mem [DEPTH];

    logic w_sample;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_hit;
    logic w_stamp_en;

    assign w_sample   = ((r_state == S_ARMED) || (r_state == S_CAPTURE)) && core_valid;
    assign w_full     = (r_count == c_cnt_w'(DEPTH));
    assign w_pop      = (r_count != '0) && rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push     = w_sample && (!w_full || w_pop);
    assign w_hit      = (STOP_COUNT != 0) && w_sample &&
                        ((r_captured + 1'b1) == c_cap_w'(STOP_COUNT));
    // The stamp runs every CAPTURE cycle so idle core cycles show as gaps.
    assign w_stamp_en = (r_state == S_CAPTURE) || ((r_state == S_ARMED) && core_valid);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_stamp    <= '0;
            r_captured <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_halt     <= 1'b0;
        end else if (clear) begin
            r_state    <= S_IDLE;
            r_stamp    <= '0;
            r_captured <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_halt     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:            if (arm) r_state <= S_ARMED;
                S_ARMED, S_CAPTURE: begin
                    if (w_hit)         r_state <= S_DONE;
                    else if (w_sample) r_state <= S_CAPTURE;
                end
                S_DONE:            r_state <= S_DONE;
                default:           r_state <= S_IDLE;
            endcase

            if (w_stamp_en)
                r_stamp <= r_stamp + 1'b1;
            if ((STOP_COUNT != 0) && w_sample && (r_captured != c_cap_w'(STOP_COUNT)))
                r_captured <= r_captured + 1'b1;
            if (w_hit)
                r_halt <= 1'b1;
            if (w_sample && w_full && !w_pop)
                r_overflow <= 1'b1;

            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge clock) begin
        if (w_push && !clear)
            r_mem[r_wptr] <= {r_stamp, ctrl_in, pc_in, alu_result, mem_rdata, mem_wdata};
    end

    assign rd_valid = (r_count != '0);
    assign rd_data  = rd_valid ? r_mem[r_rptr] : '0;
    assign level    = 6'(r_count);
    assign overflow = r_overflow;
    assign halt_req = r_halt;
    assign busy     = (r_state == S_ARMED) || (r_state == S_CAPTURE);

endmodule
`default_nettype wire

// File: tb/tb_nrisc_trace_buffer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module     : tb_nrisc_trace_buffer
// Description: Self-checking bench for nrisc_trace_buffer against a queue model.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_nrisc_trace_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, arm, clear, core_valid, rd_ready;
    logic [7:0] pc_in, alu_result, mem_rdata, mem_wdata;
    logic [9:0] ctrl_in;

    logic        a_valid, b_valid, a_ovf, b_ovf, a_halt, b_halt, a_busy, b_busy;
    logic [57:0] a_data, b_data;
    logic [5:0]  a_level, b_level;

    nrisc_trace_buffer #(.DEPTH(32), .STAMP_W(16), .STOP_COUNT(30)) u_dut_a (
        .clock(clk), .reset(reset), .arm(arm), .clear(clear), .core_valid(core_valid),
        .pc_in(pc_in), .alu_result(alu_result), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
        .ctrl_in(ctrl_in), .rd_ready(rd_ready), .rd_valid(a_valid), .rd_data(a_data),
        .level(a_level), .overflow(a_ovf), .halt_req(a_halt), .busy(a_busy)
    );

    nrisc_trace_buffer #(.DEPTH(4), .STAMP_W(16), .STOP_COUNT(0)) u_dut_b (
        .clock(clk), .reset(reset), .arm(arm), .clear(clear), .core_valid(core_valid),
        .pc_in(pc_in), .alu_result(alu_result), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
        .ctrl_in(ctrl_in), .rd_ready(rd_ready), .rd_valid(b_valid), .rd_data(b_data),
        .level(b_level), .overflow(b_ovf), .halt_req(b_halt), .busy(b_busy)
    );

    // Which instance the model is currently tracking.
    logic        sel = 1'b0;
    logic        obs_valid, obs_ovf, obs_halt, obs_busy;
    logic [57:0] obs_data;
    logic [5:0]  obs_level;
    assign obs_valid = sel ? b_valid : a_valid;
    assign obs_data  = sel ? b_data  : a_data;
    assign obs_level = sel ? b_level : a_level;
    assign obs_ovf   = sel ? b_ovf   : a_ovf;
    assign obs_halt  = sel ? b_halt  : a_halt;
    assign obs_busy  = sel ? b_busy  : a_busy;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 armed, 2 capture, 3 done.
    int          m_mode, m_stamp, m_captured, m_depth, m_stop;
    bit          m_ovf, m_halt;
    logic [57:0] m_q[$];

    task automatic m_reset();
        m_mode = 0; m_stamp = 0; m_captured = 0; m_ovf = 0; m_halt = 0;
        m_q.delete();
    endtask

    task automatic m_edge();
        bit          pop, sample;
        logic [57:0] e;
        if (clear) begin
            m_reset();
            return;
        end
        pop    = (m_q.size() != 0) && rd_ready;
        sample = ((m_mode == 1) || (m_mode == 2)) && core_valid;
        e      = {16'(m_stamp), ctrl_in, pc_in, alu_result, mem_rdata, mem_wdata};
        if (pop) void'(m_q.pop_front());
        if (sample) begin
            if (m_q.size() < m_depth) m_q.push_back(e);
            else                      m_ovf = 1;
            m_captured++;
        end
        if (m_mode == 0) begin
            if (arm) m_mode = 1;
        end else if (m_mode != 3) begin
            if (sample || m_mode == 2) m_stamp = (m_stamp + 1) % 65536;
            if (sample) m_mode = 2;
            if (m_stop != 0 && sample && m_captured == m_stop) begin
                m_mode = 3;
                m_halt = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        logic [57:0] e;
        e = (m_q.size() != 0) ? m_q[0] : 58'd0;
        chk("rd_valid", 64'(obs_valid), 64'(m_q.size() != 0));
        chk("rd_data",  64'(obs_data),  64'(e));
        chk("level",    64'(obs_level), 64'(m_q.size()));
        chk("overflow", 64'(obs_ovf),   64'(m_ovf));
        chk("halt_req", 64'(obs_halt),  64'(m_halt));
        chk("busy",     64'(obs_busy),  64'((m_mode == 1) || (m_mode == 2)));
    endtask

    task automatic drive(input bit a, input bit c, input bit cv, input bit rr, input logic [7:0] pc);
        arm = a; clear = c; core_valid = cv; rd_ready = rr; pc_in = pc;
        alu_result = 8'($urandom); mem_rdata = 8'($urandom);
        mem_wdata  = 8'($urandom); ctrl_in   = 10'($urandom);
    endtask

    task automatic step();
        m_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        m_reset();
        check_all();
        chk("rst_level", 64'(obs_level), 64'd0);
        chk("rst_data",  64'(obs_data),  64'd0);
        @(negedge clk) reset = 1'b1;
    endtask

    initial begin
        m_depth = 32; m_stop = 30;
        reset = 1'b1;
        drive(0, 0, 0, 0, 8'h00);
        #2 reset = 1'b0;
        #1;
        m_reset();
        check_all();
        chk("b_rst_valid", 64'(b_valid), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        // Fill with incrementing PC until the stop count halts capture.
        drive(1, 0, 0, 0, 8'h00); step();
        drive(0, 0, 0, 0, 8'h00); step();
        for (int i = 0; i < 35; i++) begin
            drive(0, 0, 1, 0, 8'(i)); step();
        end
        chk("t2_level", 64'(obs_level), 64'd30);
        chk("t2_halt",  64'(obs_halt),  64'd1);
        chk("t2_busy",  64'(obs_busy),  64'd0);
        chk("t1_head_stamp", 64'(obs_data[57:42]), 64'd0);
        chk("t1_head_pc",    64'(obs_data[31:24]), 64'd0);
        for (int i = 0; i < 31; i++) begin
            if (i < 30) chk("t2_drain_stamp", 64'(obs_data[57:42]), 64'(i));
            drive(0, 0, $urandom_range(0, 1) == 1, 1, 8'($urandom)); step();
        end
        chk("t2_empty", 64'(obs_valid), 64'd0);

        // Gap in core_valid leaves a hole in the stamps.
        drive(0, 1, 0, 0, 8'h00); step();
        drive(1, 0, 0, 0, 8'h00); step();
        drive(0, 0, 1, 0, 8'h10); step();
        drive(0, 0, 0, 0, 8'h11); step();
        drive(0, 0, 1, 0, 8'h12); step();
        drive(0, 0, 1, 0, 8'h13); step();
        chk("t4_level", 64'(obs_level), 64'd3);
        chk("t4_head0", 64'(obs_data[57:42]), 64'd0);
        drive(0, 0, 0, 1, 8'h14); step();
        chk("t4_head2", 64'(obs_data[57:42]), 64'd2);

        // Head held while not ready, then a single pop.
        drive(0, 1, 0, 0, 8'h00); step();
        drive(1, 0, 0, 0, 8'h00); step();
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 1, 0, 8'($urandom)); step();
            chk("t5_hold_stamp", 64'(obs_data[57:42]), 64'd0);
        end
        drive(0, 0, 1, 1, 8'($urandom)); step();
        chk("t5_next_stamp", 64'(obs_data[57:42]), 64'd1);
        drive(0, 0, 1, 0, 8'($urandom)); step();
        chk("t6_level7", 64'(obs_level), 64'd7);
        async_reset();

        // Clear while draining.
        drive(1, 0, 0, 0, 8'h00); step();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0, 8'($urandom)); step();
        end
        drive(0, 0, 0, 1, 8'h00); step();
        drive(0, 0, 0, 1, 8'h00); step();
        drive(1, 1, 1, 1, 8'h55); step();
        chk("t6_clr_level", 64'(obs_level), 64'd0);
        chk("t6_clr_valid", 64'(obs_valid), 64'd0);
        chk("t6_clr_busy",  64'(obs_busy),  64'd0);

        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 8'($urandom));
            step();
        end

        // Small FIFO, halt disabled: overflow behaviour.
        sel = 1'b1; m_depth = 4; m_stop = 0;
        drive(0, 0, 0, 0, 8'h00);
        async_reset();
        drive(1, 0, 0, 0, 8'h00); step();
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 1, 0, 8'(i)); step();
            if (i == 3) chk("t3_no_ovf", 64'(obs_ovf), 64'd0);
            if (i == 4) chk("t3_ovf",    64'(obs_ovf), 64'd1);
        end
        chk("t3_level",  64'(obs_level), 64'd4);
        chk("t3_head",   64'(obs_data[57:42]), 64'd0);
        drive(0, 0, 1, 1, 8'h77); step();
        chk("t3_full_pp_level", 64'(obs_level), 64'd4);
        chk("t3_full_pp_ovf",   64'(obs_ovf),   64'd1);
        chk("t3_full_pp_head",  64'(obs_data[57:42]), 64'd1);
        chk("t3_no_halt",       64'(obs_halt),  64'd0);

        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 8'($urandom));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
